// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC and the IF/ID register, keeps one
// imem request in flight plus a one-entry response buffer; redirects kill in-flight fetches.
module fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  PCSrc,
   input  logic        PC_Write,
   input  logic        IFID_Write,
   input  logic        IFID_Flush,
   input  logic [31:0] Branch_Target,
   input  logic [31:0] JumpR_Target,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic [31:0] IFID_Instr,
   output logic [31:0] IFID_PC,
   output logic [31:0] IFID_PCPlus4,
   output logic        IFID_Valid
);

   typedef enum logic {S_REQ, S_WAIT} state_t;

   state_t      state_reg;
   logic [31:0] pc_reg;
   logic [31:0] fetch_pc_reg;
   logic        kill_reg;
   logic        buf_valid_reg;
   logic [31:0] buf_instr_reg;
   logic [31:0] buf_pc_reg;
   logic        stale_rsp_reg;

   logic        redirect;
   logic [31:0] redirect_pc;
   logic        rsp_arrive;
   logic        rsp_good;
   logic        ifid_take;
   logic        rsp_bypass;
   logic        rsp_to_buf;
   logic        accept;

   always_comb begin
      redirect_pc = pc_reg;
      case (PCSrc)
         2'b01:   redirect_pc = {IFID_PCPlus4[31:28], IFID_Instr[25:0], 2'b00};
         2'b10:   redirect_pc = JumpR_Target;
         2'b11:   redirect_pc = Branch_Target;
         default: redirect_pc = pc_reg;
      endcase
   end

   assign redirect   = PC_Write && (PCSrc != 2'b00);
   assign rsp_arrive = imem_rsp_valid && (state_reg == S_WAIT);
   assign rsp_good   = rsp_arrive && !kill_reg && !redirect;
   assign ifid_take  = IFID_Write && !IFID_Flush;
   assign rsp_bypass = rsp_good && ifid_take && !buf_valid_reg;
   assign rsp_to_buf = rsp_good && !rsp_bypass;

   // A finishing fetch frees the port this cycle unless its word has to park in the buffer.
   assign imem_req_valid = ((state_reg == S_REQ) && !buf_valid_reg) || (rsp_arrive && !rsp_to_buf);
   assign imem_addr      = pc_reg;
   assign accept         = imem_req_valid && imem_req_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= S_REQ;
         pc_reg        <= RESET_PC;
         fetch_pc_reg  <= RESET_PC;
         kill_reg      <= 1'b0;
         buf_valid_reg <= 1'b0;
         buf_instr_reg <= NOP_INSTR;
         buf_pc_reg    <= 32'h0;
         IFID_Instr    <= NOP_INSTR;
         IFID_PC       <= 32'h0;
         IFID_PCPlus4  <= 32'h0;
         IFID_Valid    <= 1'b0;
      end else begin
         if (redirect) begin
            pc_reg <= redirect_pc;
         end else if (accept) begin
            pc_reg <= pc_reg + 32'd4;
         end

         if (accept) begin
            fetch_pc_reg <= pc_reg;
            state_reg    <= S_WAIT;
            kill_reg     <= redirect;
         end else if (rsp_arrive) begin
            state_reg <= S_REQ;
            kill_reg  <= 1'b0;
         end else if (redirect && (state_reg == S_WAIT)) begin
            kill_reg <= 1'b1;
         end

         if (redirect) begin
            buf_valid_reg <= 1'b0;
         end else if (rsp_to_buf) begin
            buf_valid_reg <= 1'b1;
            buf_instr_reg <= imem_rsp_data;
            buf_pc_reg    <= fetch_pc_reg;
         end else if (ifid_take) begin
            buf_valid_reg <= 1'b0;
         end

         // Bubbles and flushes keep the PC tags of the last real instruction.
         if (IFID_Flush) begin
            IFID_Instr <= NOP_INSTR;
            IFID_Valid <= 1'b0;
         end else if (IFID_Write) begin
            if (buf_valid_reg) begin
               IFID_Instr   <= buf_instr_reg;
               IFID_PC      <= buf_pc_reg;
               IFID_PCPlus4 <= buf_pc_reg + 32'd4;
               IFID_Valid   <= 1'b1;
            end else if (rsp_good) begin
               IFID_Instr   <= imem_rsp_data;
               IFID_PC      <= fetch_pc_reg;
               IFID_PCPlus4 <= fetch_pc_reg + 32'd4;
               IFID_Valid   <= 1'b1;
            end else begin
               IFID_Instr <= NOP_INSTR;
               IFID_Valid <= 1'b0;
            end
         end
      end
   end

   // Remembers that reset abandoned a request, so its late response is not flagged as unsolicited.
   always_ff @(posedge clk) begin
      if (reset) begin
         stale_rsp_reg <= stale_rsp_reg || (state_reg == S_WAIT);
      end else if (imem_rsp_valid && (state_reg == S_REQ)) begin
         stale_rsp_reg <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         assert (!(imem_rsp_valid && (state_reg == S_REQ) && !stale_rsp_reg));
         assert (!(imem_rsp_valid && buf_valid_reg && !stale_rsp_reg));
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: variable-latency imem model, transaction-level fetch
// model checked every cycle, plus literal expectations for the directed scenarios.
module tb_fetch_unit;

   localparam logic [31:0] RESET_PC  = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [1:0]  PCSrc = 2'b00;
   logic        PC_Write = 1'b1;
   logic        IFID_Write = 1'b1;
   logic        IFID_Flush = 1'b0;
   logic [31:0] Branch_Target = 32'h0;
   logic [31:0] JumpR_Target = 32'h0;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b1;
   logic [31:0] imem_addr;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = 32'h0;
   logic [31:0] IFID_Instr;
   logic [31:0] IFID_PC;
   logic [31:0] IFID_PCPlus4;
   logic        IFID_Valid;

   fetch_unit #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
      .clk(clk), .reset(reset), .PCSrc(PCSrc), .PC_Write(PC_Write),
      .IFID_Write(IFID_Write), .IFID_Flush(IFID_Flush),
      .Branch_Target(Branch_Target), .JumpR_Target(JumpR_Target),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
      .imem_addr(imem_addr), .imem_rsp_valid(imem_rsp_valid),
      .imem_rsp_data(imem_rsp_data), .IFID_Instr(IFID_Instr), .IFID_PC(IFID_PC),
      .IFID_PCPlus4(IFID_PCPlus4), .IFID_Valid(IFID_Valid)
   );

   always #5 clk = ~clk;

   // Memory: in-order responses, lat cycles after acceptance.
   typedef struct {logic [31:0] addr; int due;} mreq_t;
   mreq_t mq[$];
   int cyc = 0;
   int lat = 1;

   // Model: next fetch address, in-flight fetches with a killed flag, parked words, IF/ID contents.
   typedef struct {logic [31:0] addr; bit killed;} fetch_t;
   typedef struct {logic [31:0] instr; logic [31:0] pc;} word_t;
   fetch_t      m_out[$];
   word_t       m_buf[$];
   logic [31:0] m_pc, m_instr, m_ipc, m_ip4;
   logic        m_valid;

   int n_checks = 0;
   int n_pass = 0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a == 32'h1000_0020) ? 32'h0800_0040 : a;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic idle();
      PCSrc = 2'b00; PC_Write = 1'b1; IFID_Write = 1'b1; IFID_Flush = 1'b0;
   endtask

   task automatic tick();
      bit redirect, arrive, good, take, bypass, store, req_exp, m_acc, mem_accept;
      logic [31:0] target, mem_addr;
      word_t w;
      mem_accept = 1'b0;
      mem_addr = 32'h0;
      @(negedge clk);
      if (reset) begin
         m_pc = RESET_PC; m_out.delete(); m_buf.delete();
         m_instr = NOP_INSTR; m_ipc = 32'h0; m_ip4 = 32'h0; m_valid = 1'b0;
      end else begin
         chk("ifid_valid", IFID_Valid, m_valid);
         chk("ifid_instr", IFID_Instr, m_instr);
         chk("ifid_pc", IFID_PC, m_ipc);
         chk("ifid_pcplus4", IFID_PCPlus4, m_ip4);
         redirect = PC_Write && (PCSrc != 2'b00);
         case (PCSrc)
            2'b01:   target = {m_ip4[31:28], m_instr[25:0], 2'b00};
            2'b10:   target = JumpR_Target;
            2'b11:   target = Branch_Target;
            default: target = m_pc;
         endcase
         arrive  = imem_rsp_valid && (m_out.size() > 0);
         good    = arrive && !m_out[0].killed && !redirect;
         take    = IFID_Write && !IFID_Flush;
         bypass  = good && take && (m_buf.size() == 0);
         store   = good && !bypass;
         req_exp = (m_buf.size() == 0) && ((m_out.size() == 0) || arrive) && !store;
         chk("req_valid", imem_req_valid, req_exp);
         if (req_exp) chk("imem_addr", imem_addr, m_pc);
         m_acc = req_exp && imem_req_ready;
         if (IFID_Flush) begin
            m_instr = NOP_INSTR; m_valid = 1'b0;
         end else if (IFID_Write) begin
            if (m_buf.size() > 0) begin
               w = m_buf.pop_front();
               m_instr = w.instr; m_ipc = w.pc; m_ip4 = w.pc + 32'd4; m_valid = 1'b1;
            end else if (good) begin
               m_instr = mem_word(m_out[0].addr); m_ipc = m_out[0].addr;
               m_ip4 = m_out[0].addr + 32'd4; m_valid = 1'b1;
            end else begin
               m_instr = NOP_INSTR; m_valid = 1'b0;
            end
         end
         if (store) m_buf.push_back('{mem_word(m_out[0].addr), m_out[0].addr});
         if (redirect) m_buf.delete();
         if (arrive) void'(m_out.pop_front());
         if (redirect) foreach (m_out[i]) m_out[i].killed = 1'b1;
         if (m_acc) m_out.push_back('{m_pc, redirect});
         if (redirect) m_pc = target;
         else if (m_acc) m_pc = m_pc + 32'd4;
         mem_accept = imem_req_valid && imem_req_ready;
         mem_addr = imem_addr;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (mem_accept) mq.push_back('{mem_addr, cyc - 1 + lat});
      if ((mq.size() > 0) && (mq[0].due <= cyc)) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data = mem_word(mq[0].addr);
         void'(mq.pop_front());
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data = 32'hDEAD_BEEF;
      end
   endtask

   task automatic wait_req(input logic [31:0] a, input string name);
      bit seen = 1'b0;
      for (int i = 0; i < 12 && !seen; i++) begin
         #2;
         if (imem_req_valid && (imem_addr == a)) seen = 1'b1;
         tick();
      end
      n_checks++;
      if (seen) n_pass++;
      else $display("FAIL %s: request to %h not seen, last addr %h", name, a, imem_addr);
   endtask

   task automatic wait_valid(input logic [31:0] exp_pc, input string name);
      for (int i = 0; i < 16; i++) begin
         #1;
         if (IFID_Valid) break;
         tick();
      end
      chk({name, "_valid"}, IFID_Valid, 1);
      chk({name, "_pc"}, IFID_PC, exp_pc);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got cycle %0d expected under 5000", cyc);
      $fatal(1);
   end

   initial begin
      // Reset, then streaming with a 1-cycle memory.
      reset = 1'b1; idle();
      tick(); tick();
      reset = 1'b0;
      #2;
      chk("first_req_valid", imem_req_valid, 1);
      chk("first_req_addr", imem_addr, RESET_PC);
      chk("reset_valid", IFID_Valid, 0);
      chk("reset_instr", IFID_Instr, NOP_INSTR);
      tick(); tick();
      chk("seq_pc0", IFID_PC, 32'h0);
      chk("seq_p4_0", IFID_PCPlus4, 32'h4);
      chk("seq_valid0", IFID_Valid, 1);
      tick();
      chk("seq_pc4", IFID_PC, 32'h4);
      chk("seq_instr4", IFID_Instr, 32'h4);

      // Load-use stall on the cycle the 0x10 word arrives.
      for (int i = 0; i < 20; i++) begin
         #2;
         if (imem_rsp_valid && (imem_rsp_data == 32'h10)) break;
         tick();
      end
      IFID_Write = 1'b0; PC_Write = 1'b0;
      tick();
      idle();
      chk("stall_hold_pc", IFID_PC, 32'h0C);
      chk("stall_hold_valid", IFID_Valid, 1);
      tick();
      chk("stall_buf_pc", IFID_PC, 32'h10);
      chk("stall_buf_instr", IFID_Instr, 32'h10);
      tick(); tick(); tick();

      // Branch while a 3-cycle fetch of 0x30 is outstanding.
      lat = 3;
      for (int i = 0; i < 60; i++) begin
         #2;
         if ((mq.size() > 0) && (mq[0].addr == 32'h30) && !imem_rsp_valid) break;
         tick();
      end
      PCSrc = 2'b11; Branch_Target = 32'h200; IFID_Flush = 1'b1;
      tick();
      idle();
      chk("branch_model_pc", m_pc, 32'h200);
      chk("branch_flush_valid", IFID_Valid, 0);
      wait_req(32'h200, "branch_req");
      wait_valid(32'h200, "branch_first");

      // JumpR on a cycle with both a response and an accepted request.
      lat = 1;
      for (int i = 0; i < 20; i++) begin
         #2;
         if (imem_rsp_valid && imem_req_valid) break;
         tick();
      end
      PCSrc = 2'b10; JumpR_Target = 32'h44; IFID_Flush = 1'b1;
      tick();
      idle();
      chk("jumpr_model_pc", m_pc, 32'h44);
      chk("jumpr_flush_valid", IFID_Valid, 0);
      wait_req(32'h44, "jumpr_req");
      wait_valid(32'h44, "jumpr_first");

      // Jump with IF/ID stalled and flushed; target built from IFID_PCPlus4 and instr index.
      for (int i = 0; i < 20; i++) begin
         #2;
         if (imem_rsp_valid && imem_req_valid) break;
         tick();
      end
      PCSrc = 2'b10; JumpR_Target = 32'h1000_0020; IFID_Flush = 1'b1;
      tick();
      idle();
      wait_valid(32'h1000_0020, "jump_src");
      chk("jump_src_instr", IFID_Instr, 32'h0800_0040);
      PCSrc = 2'b01; IFID_Write = 1'b0; IFID_Flush = 1'b1;
      tick();
      idle();
      chk("jump_nop_instr", IFID_Instr, NOP_INSTR);
      chk("jump_nop_valid", IFID_Valid, 0);
      chk("jump_hold_pc", IFID_PC, 32'h1000_0020);
      chk("jump_model_pc", m_pc, 32'h1000_0100);
      wait_req(32'h1000_0100, "jump_req");
      wait_valid(32'h1000_0100, "jump_first");

      // Reset while a 2-cycle fetch is outstanding; its response lands after reset.
      lat = 2;
      for (int i = 0; i < 20; i++) begin
         #2;
         if ((mq.size() > 0) && (mq[0].due == cyc + 1) && !imem_rsp_valid) break;
         tick();
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #2;
      chk("late_rsp_present", imem_rsp_valid, 1);
      chk("post_reset_req", imem_req_valid, 1);
      chk("post_reset_addr", imem_addr, RESET_PC);
      chk("post_reset_valid", IFID_Valid, 0);
      tick();
      wait_valid(RESET_PC, "post_reset_first");
      tick(); tick(); tick(); tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
